// File: rtl/mdu_multicycle_pkg.sv
// Shared ALU select codes, MDU state encodings and small helpers
// for the RV32M multiply/divide unit.
package mdu_multicycle_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_ITER = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic is_m_op(input logic [4:0] sel);
        case (sel)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: is_m_op = 1'b1;
            default:                              is_m_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [4:0] sel);
        case (sel)
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: is_div_op = 1'b1;
            default:                              is_div_op = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        neg32 = ~v + 32'd1;
    endfunction

endpackage

// File: rtl/mdu_multicycle_div_step.sv
// One restoring-divide step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic [XLEN-1:0] quo_in,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // Trial subtraction; the top bit of the difference is the borrow.
    always_comb begin
        shifted_s = {rem_in, quo_in[XLEN-1]};
        diff_s    = shifted_s - {1'b0, divisor};
        if (!diff_s[XLEN]) begin
            rem_out = diff_s[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shifted_s[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_multicycle.sv
// Multi-cycle RV32M multiply/divide unit: 32-step shift-add multiplier and
// restoring divider sharing one accumulator pair, with a sign-fix stage.
module mdu_multicycle
    import mdu_multicycle_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(ITERS);

    mdu_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  acc_hi_r;
    logic [XLEN-1:0]  acc_lo_r;
    logic [XLEN-1:0]  opnd_r;
    logic [4:0]       op_r;
    logic             sa_r;
    logic             sb_r;
    logic             busy_r;
    logic             done_r;
    logic [XLEN-1:0]  result_r;

    logic             sa_s;
    logic             sb_s;
    logic [XLEN-1:0]  mag_a_s;
    logic [XLEN-1:0]  mag_b_s;
    logic             fast_s;
    logic [XLEN-1:0]  fast_res_s;
    logic [XLEN:0]    mul_sum_s;
    logic [XLEN-1:0]  div_rem_s;
    logic [XLEN-1:0]  div_quo_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]  fix_res_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // Operand signedness and magnitudes for the incoming request.
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        case (alu_sel)
            ALU_MULH, ALU_DIV, ALU_REM: begin
                sa_s = op_a[XLEN-1];
                sb_s = op_b[XLEN-1];
            end
            ALU_MULHSU: sa_s = op_a[XLEN-1];
            default: begin
                sa_s = 1'b0;
                sb_s = 1'b0;
            end
        endcase
        mag_a_s = sa_s ? neg32(op_a) : op_a;
        mag_b_s = sb_s ? neg32(op_b) : op_b;
    end

    // Divide-by-zero and signed overflow resolve without iterating.
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = 32'h0000_0000;
        if (is_div_op(alu_sel) && (op_b == 32'h0000_0000)) begin
            fast_s     = 1'b1;
            fast_res_s = ((alu_sel == ALU_DIV) || (alu_sel == ALU_DIVU)) ? 32'hFFFF_FFFF : op_a;
        end else if (((alu_sel == ALU_DIV) || (alu_sel == ALU_REM)) &&
                     (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF)) begin
            fast_s     = 1'b1;
            fast_res_s = (alu_sel == ALU_DIV) ? 32'h8000_0000 : 32'h0000_0000;
        end else begin
            fast_s     = 1'b0;
            fast_res_s = 32'h0000_0000;
        end
    end

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc_hi_r),
        .divisor (opnd_r),
        .quo_in  (acc_lo_r),
        .rem_out (div_rem_s),
        .quo_out (div_quo_s)
    );

    // Multiply step adds the multiplicand into the high half, then shifts right.
    assign mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : 33'd0);

    // Sign correction and result selection for the FIX state.
    always_comb begin
        prod_s     = {acc_hi_r, acc_lo_r};
        prod_fix_s = (sa_r ^ sb_r) ? (~prod_s + 64'd1) : prod_s;
        case (op_r)
            ALU_MUL:                          fix_res_s = prod_fix_s[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                fix_res_s = (sa_r ^ sb_r) ? neg32(acc_lo_r) : acc_lo_r;
            ALU_REM, ALU_REMU:                fix_res_s = sa_r ? neg32(acc_hi_r) : acc_hi_r;
            default:                          fix_res_s = 32'h0000_0000;
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= MDU_IDLE;
            cnt_r    <= '0;
            acc_hi_r <= 32'h0000_0000;
            acc_lo_r <= 32'h0000_0000;
            opnd_r   <= 32'h0000_0000;
            op_r     <= 5'd0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'h0000_0000;
        end else if (kill) begin
            state_r <= MDU_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    done_r <= 1'b0;
                    if (start && is_m_op(alu_sel)) begin
                        op_r <= alu_sel;
                        sa_r <= sa_s;
                        sb_r <= sb_s;
                        if (fast_s) begin
                            result_r <= fast_res_s;
                            done_r   <= 1'b1;
                        end else begin
                            state_r  <= MDU_ITER;
                            busy_r   <= 1'b1;
                            cnt_r    <= '0;
                            acc_hi_r <= 32'h0000_0000;
                            // Dividend/multiplier shifts through acc_lo; opnd holds divisor/multiplicand.
                            acc_lo_r <= is_div_op(alu_sel) ? mag_a_s : mag_b_s;
                            opnd_r   <= is_div_op(alu_sel) ? mag_b_s : mag_a_s;
                        end
                    end
                end
                MDU_ITER: begin
                    if (is_div_op(op_r)) begin
                        acc_hi_r <= div_rem_s;
                        acc_lo_r <= div_quo_s;
                    end else begin
                        acc_hi_r <= mul_sum_s[XLEN:1];
                        acc_lo_r <= {mul_sum_s[0], acc_lo_r[XLEN-1:1]};
                    end
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(ITERS - 1)) begin
                        state_r <= MDU_FIX;
                    end else begin
                        state_r <= MDU_ITER;
                    end
                end
                MDU_FIX: begin
                    result_r <= fix_res_s;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= MDU_IDLE;
                end
                default: begin
                    state_r <= MDU_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Scoreboard bench for mdu_multicycle: directed ops push expected result and
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_mdu_multicycle;
    import mdu_multicycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [4:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] last_res;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sbq[$];

    mdu_multicycle #(.XLEN(32), .ITERS(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .alu_sel (alu_sel),
        .op_a    (op_a),
        .op_b    (op_b),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", result, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check($sformatf("result_op%0d", e.id), result, e.res);
                check($sformatf("done_cycle_op%0d", e.id), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one op at the current negedge; returns at the negedge of T+34.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input bit fast, input int id);
        int   t;
        int   nb;
        exp_t e;
        alu_sel = sel;
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        t       = cyc;
        e.res   = expv;
        e.cyc   = fast ? t + 1 : t + 34;
        e.id    = id;
        sbq.push_back(e);
        last_res = expv;
        @(negedge clk);
        start   = 1'b0;
        alu_sel = ALU_ADD;
        op_a    = $urandom;
        op_b    = $urandom;
        nb = 0;
        for (int i = 1; i <= 34; i++) begin
            nb += int'(busy);
            if (i < 34) @(negedge clk);
        end
        check($sformatf("busy_cycles_op%0d", id), 32'(nb), fast ? 32'd0 : 32'd33);
    endtask

    // Hold in IDLE for n cycles and count busy cycles.
    task automatic idle_count(input int n, input string name);
        int nb;
        nb = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            nb += int'(busy);
        end
        check(name, 32'(nb), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        kill     = 1'b0;
        alu_sel  = ALU_ADD;
        op_a     = 32'd0;
        op_b     = 32'd0;
        last_res = 32'd0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Iterative ops, issued back to back in each done cycle.
        run_op(ALU_MUL,    32'd7,         32'd6,         32'h0000_002A, 1'b0, 1);
        run_op(ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2);
        run_op(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 3);
        run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 4);
        run_op(ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5);
        run_op(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 6);
        run_op(ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 7);
        run_op(ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 8);
        run_op(ALU_DIVU,   32'd100,       32'd7,         32'h0000_000E, 1'b0, 9);
        run_op(ALU_REMU,   32'd100,       32'd7,         32'h0000_0002, 1'b0, 10);
        run_op(ALU_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 11);
        run_op(ALU_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 12);

        // Fast path: done at T+1, busy never raised.
        run_op(ALU_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 13);
        run_op(ALU_REM,    32'd5,         32'd0,         32'h0000_0005, 1'b1, 14);
        run_op(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 15);
        run_op(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 16);

        // Kill mid-divide at T+10.
        @(negedge clk);
        alu_sel = ALU_DIV;
        op_a    = 32'd100;
        op_b    = 32'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_kill", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("busy_after_kill", {31'd0, busy}, 32'd0);
        check("done_after_kill", {31'd0, done}, 32'd0);
        check("result_after_kill", result, last_res);
        idle_count(40, "busy_post_kill");

        // kill and start together in IDLE.
        alu_sel = ALU_MUL;
        op_a    = 32'd3;
        op_b    = 32'd4;
        start   = 1'b1;
        kill    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        idle_count(36, "busy_kill_start");

        // Non-M code is ignored.
        alu_sel = ALU_ADD;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle_count(36, "busy_add_code");
        check("result_after_ignored", result, last_res);

        // Asynchronous reset at T+5 of a multiply.
        alu_sel = ALU_MUL;
        op_a    = 32'd9;
        op_b    = 32'd9;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", {31'd0, busy}, 32'd0);
        check("midop_reset_done", {31'd0, done}, 32'd0);
        check("midop_reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(ALU_MUL,    32'd3,         32'd3,         32'h0000_0009, 1'b0, 17);
        run_op(ALU_DIVU,   32'd100,       32'd7,         32'h0000_000E, 1'b0, 18);
        run_op(ALU_REMU,   32'd5,         32'd0,         32'h0000_0005, 1'b1, 19);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
